// File: rtl/io_port_responder_pkg.sv
// Shared types and constants for the memory-mapped byte I/O responder.
package io_port_pkg;

    // Request sequencing states.
    typedef enum logic [1:0] {
        StIdle,
        StWaitTx,
        StWaitRx,
        StResp
    } state_e;

    // Register offsets within the 4-word window (i_ADDR[1:0]).
    localparam logic [1:0] RegTxData = 2'd0;
    localparam logic [1:0] RegRxData = 2'd1;
    localparam logic [1:0] RegStatus = 2'd2;

    // STATUS register bit positions.
    localparam int unsigned StatusTxFull     = 0;
    localparam int unsigned StatusTxEmpty    = 1;
    localparam int unsigned StatusRxAvail    = 2;
    localparam int unsigned StatusRxOverflow = 3;
    localparam int unsigned StatusRxTimeout  = 4;

    // Load result returned when an RXDATA read gives up waiting.
    localparam logic [15:0] RxTimeoutData = 16'hFFFF;

endpackage

// File: rtl/io_port_responder_if.sv
// CPU data-bus and byte-stream device signals of the I/O responder.
interface io_port_responder_if;

    logic [15:0] i_ADDR;
    logic [15:0] i_WDATA;
    logic        f_WRITE;
    logic        f_READ;
    logic [15:0] o_RDATA;
    logic        o_RVALID;
    logic        o_IOPAUSE;
    logic [7:0]  o_TXDATA;
    logic        o_TXVALID;
    logic        i_TXREADY;
    logic [7:0]  i_RXDATA;
    logic        i_RXVALID;
    logic        o_RXREADY;

    // Environment side: CPU plus external device.
    modport master (
        output i_ADDR, i_WDATA, f_WRITE, f_READ, i_TXREADY, i_RXDATA, i_RXVALID,
        input  o_RDATA, o_RVALID, o_IOPAUSE, o_TXDATA, o_TXVALID, o_RXREADY
    );

    // Responder side.
    modport slave (
        input  i_ADDR, i_WDATA, f_WRITE, f_READ, i_TXREADY, i_RXDATA, i_RXVALID,
        output o_RDATA, o_RVALID, o_IOPAUSE, o_TXDATA, o_TXVALID, o_RXREADY
    );

endinterface

// File: rtl/io_port_responder_byte_fifo.sv
// Byte FIFO with wrap-bit pointers. A push while full is accepted when a pop
// happens in the same cycle; a pop while empty is ignored.
module byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic [7:0] push_data_i,
    input  logic       pop_i,
    output logic [7:0] head_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic [7:0]  mem_d [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    // Next-state for storage and pointers.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data_i;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/io_port_responder.sv
// Memory-mapped byte I/O responder: services CPU loads/stores in a 4-word
// window and buffers bytes to/from an external device, pausing the CPU while
// a request cannot complete.
module io_port_responder #(
    parameter logic [15:0] BASE_ADDR  = 16'hFF00,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RX_TIMEOUT = 1023
) (
    input logic                i_CLOCK,
    input logic                i_RESET_N,
    io_port_responder_if.slave bus
);

    import io_port_pkg::*;

    localparam int unsigned TW = $clog2(RX_TIMEOUT + 1);
    localparam logic [TW-1:0] TimeoutLast = TW'(RX_TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [15:0]   rdata_q, rdata_d;
    logic [7:0]    tx_hold_q, tx_hold_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          rx_ovf_q, rx_ovf_d;
    logic          rx_to_q, rx_to_d;

    logic          hit, wr_req, rd_req;
    logic [1:0]    reg_sel;
    logic [15:0]   status;
    logic          tx_push, tx_pop, tx_full, tx_empty, tx_can_push;
    logic [7:0]    tx_push_data, tx_head;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]    rx_head;

    assign hit     = (bus.i_ADDR[15:2] == BASE_ADDR[15:2]);
    assign wr_req  = bus.f_WRITE && hit;
    assign rd_req  = bus.f_READ && !bus.f_WRITE && hit;
    assign reg_sel = bus.i_ADDR[1:0];

    // A device pop frees a slot in the same cycle, so a full FIFO still takes a push.
    assign tx_pop      = !tx_empty && bus.i_TXREADY;
    assign tx_can_push = !tx_full || bus.i_TXREADY;
    assign rx_push     = bus.i_RXVALID && !rx_full;

    byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_tx_fifo (
        .clk_i      (i_CLOCK),
        .rst_ni     (i_RESET_N),
        .push_i     (tx_push),
        .push_data_i(tx_push_data),
        .pop_i      (tx_pop),
        .head_o     (tx_head),
        .full_o     (tx_full),
        .empty_o    (tx_empty)
    );

    byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_rx_fifo (
        .clk_i      (i_CLOCK),
        .rst_ni     (i_RESET_N),
        .push_i     (rx_push),
        .push_data_i(bus.i_RXDATA),
        .pop_i      (rx_pop),
        .head_o     (rx_head),
        .full_o     (rx_full),
        .empty_o    (rx_empty)
    );

    // STATUS word from pre-edge FIFO state and sticky flags.
    always_comb begin
        status                   = '0;
        status[StatusTxFull]     = tx_full;
        status[StatusTxEmpty]    = tx_empty;
        status[StatusRxAvail]    = !rx_empty;
        status[StatusRxOverflow] = rx_ovf_q;
        status[StatusRxTimeout]  = rx_to_q;
    end

    // Request FSM next-state, FIFO strobes and sticky flag updates.
    always_comb begin
        state_d      = state_q;
        rdata_d      = rdata_q;
        tx_hold_d    = tx_hold_q;
        cnt_d        = cnt_q;
        rx_ovf_d     = rx_ovf_q;
        rx_to_d      = rx_to_q;
        tx_push      = 1'b0;
        tx_push_data = bus.i_WDATA[7:0];
        rx_pop       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (wr_req) begin
                    case (reg_sel)
                        RegTxData: begin
                            if (tx_can_push) begin
                                tx_push = 1'b1;
                            end else begin
                                tx_hold_d = bus.i_WDATA[7:0];
                                state_d   = StWaitTx;
                            end
                        end
                        RegStatus: begin
                            if (bus.i_WDATA[StatusRxOverflow]) rx_ovf_d = 1'b0;
                            if (bus.i_WDATA[StatusRxTimeout])  rx_to_d  = 1'b0;
                        end
                        default: ;
                    endcase
                end else if (rd_req) begin
                    state_d = StResp;
                    case (reg_sel)
                        RegRxData: begin
                            if (!rx_empty) begin
                                rx_pop  = 1'b1;
                                rdata_d = {8'h00, rx_head};
                            end else begin
                                state_d = StWaitRx;
                                cnt_d   = '0;
                            end
                        end
                        RegStatus: rdata_d = status;
                        default:   rdata_d = '0;
                    endcase
                end
            end
            StWaitTx: begin
                tx_push_data = tx_hold_q;
                if (tx_can_push) begin
                    tx_push = 1'b1;
                    state_d = StIdle;
                end
            end
            StWaitRx: begin
                if (!rx_empty) begin
                    rx_pop  = 1'b1;
                    rdata_d = {8'h00, rx_head};
                    state_d = StResp;
                end else if (cnt_q == TimeoutLast) begin
                    rdata_d = RxTimeoutData;
                    rx_to_d = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Overflow detection after the clear so a same-cycle set is not lost.
        if (bus.i_RXVALID && rx_full) begin
            rx_ovf_d = 1'b1;
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            state_q   <= StIdle;
            rdata_q   <= '0;
            tx_hold_q <= '0;
            cnt_q     <= '0;
            rx_ovf_q  <= 1'b0;
            rx_to_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            tx_hold_q <= tx_hold_d;
            cnt_q     <= cnt_d;
            rx_ovf_q  <= rx_ovf_d;
            rx_to_q   <= rx_to_d;
        end
    end

    assign bus.o_RDATA   = rdata_q;
    assign bus.o_RVALID  = (state_q == StResp);
    assign bus.o_IOPAUSE = (state_q == StWaitTx) || (state_q == StWaitRx);
    assign bus.o_TXDATA  = tx_head;
    assign bus.o_TXVALID = !tx_empty;
    assign bus.o_RXREADY = !rx_full;

endmodule
